// File: rtl/dcache_assoc.sv
// rtl/dcache_assoc.sv - set-associative write-back data cache, true LRU, dirty-victim eviction
// Optional DCACHE_STATS_EN adds saturating hit/miss/evict counters.
module dcache_assoc #(
  parameter int NUM_SETS = 16,
  parameter int NUM_WAYS = 2,
  parameter int ADDR_W   = 16
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_is_store,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_data,
  output logic        resp_valid,
  output logic        resp_hit,
  output logic        resp_is_store,
  output logic [63:0] resp_data,
  output logic [31:0] resp_addr,
  input  logic        fill_valid,
  input  logic [31:0] fill_addr,
  input  logic [63:0] fill_data,
  output logic        fill_ready,
  output logic        evict_valid,
  output logic [31:0] evict_addr,
  output logic [63:0] evict_data,
  input  logic        evict_ready
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count,
  output logic [31:0] evict_count
`endif
);
  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int TAG_W = ADDR_W - 3 - IDX_W;
  localparam int WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
  localparam int AGE_W = WAY_W;
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;

  typedef enum logic [1:0] {S_IDLE, S_EVICT, S_FILL} state_t;
  state_t r_state, w_state_nxt;

  logic [63:0]         r_data  [NUM_SETS][NUM_WAYS];
  logic [TAG_W-1:0]    r_tag   [NUM_SETS][NUM_WAYS];
  logic [NUM_WAYS-1:0] r_valid [NUM_SETS];
  logic [NUM_WAYS-1:0] r_dirty [NUM_SETS];
  logic [WAY_W-1:0]    r_victim;
  logic                r_ready_en;
  logic                r_resp_valid, r_resp_hit, r_resp_is_store;
  logic [63:0]         r_resp_data;
  logic [31:0]         r_resp_addr;

  logic [IDX_W-1:0] w_req_idx, w_fill_idx, w_touch_idx;
  logic [TAG_W-1:0] w_req_tag, w_fill_tag;
  logic             w_hit, w_req_fire, w_store_hit, w_touch;
  logic             w_dup, w_inv, w_victim_dirty;
  logic [WAY_W-1:0] w_hit_way, w_dup_way, w_inv_way, w_old_way, w_victim, w_touch_way;
  logic [63:0]      w_hit_line, w_merged;
  logic             w_unused;

  assign w_req_idx  = req_addr[2+IDX_W:3];
  assign w_req_tag  = req_addr[ADDR_W-1:3+IDX_W];
  assign w_fill_idx = fill_addr[2+IDX_W:3];
  assign w_fill_tag = fill_addr[ADDR_W-1:3+IDX_W];
  assign w_unused   = ^{fill_addr[31:ADDR_W], fill_addr[2:0]};

  always_comb begin
    w_hit = 1'b0;
    w_hit_way = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (r_valid[w_req_idx][w] && r_tag[w_req_idx][w] == w_req_tag) begin
        w_hit = 1'b1;
        w_hit_way = WAY_W'(w);
      end
    end
  end

  assign w_hit_line = r_data[w_req_idx][w_hit_way];

  always_comb begin
    w_merged = w_hit_line;
    case (req_size)
      SZ_BYTE: w_merged[{req_addr[2:0], 3'b000} +: 8]  = req_data[7:0];
      SZ_HALF: w_merged[{req_addr[2:1], 4'b0000} +: 16] = req_data[15:0];
      default: w_merged[{req_addr[2], 5'b00000} +: 32] = req_data;
    endcase
  end

  // Victim priority: resident copy of the same line, lowest invalid way, oldest way.
  always_comb begin
    w_dup = 1'b0;
    w_dup_way = '0;
    w_inv = 1'b0;
    w_inv_way = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (r_valid[w_fill_idx][w] && r_tag[w_fill_idx][w] == w_fill_tag) begin
        w_dup = 1'b1;
        w_dup_way = WAY_W'(w);
      end
      if (!r_valid[w_fill_idx][w] && !w_inv) begin
        w_inv = 1'b1;
        w_inv_way = WAY_W'(w);
      end
    end
    w_victim = w_dup ? w_dup_way : (w_inv ? w_inv_way : w_old_way);
    w_victim_dirty = !w_dup && r_valid[w_fill_idx][w_victim] && r_dirty[w_fill_idx][w_victim];
  end

  assign w_req_fire  = req_valid && req_ready;
  assign w_store_hit = w_req_fire && req_is_store && w_hit;
  assign w_touch     = (w_req_fire && w_hit) || (r_state == S_FILL);
  assign w_touch_idx = (r_state == S_FILL) ? w_fill_idx : w_req_idx;
  assign w_touch_way = (r_state == S_FILL) ? r_victim : w_hit_way;

  generate
    if (NUM_WAYS > 1) begin : g_lru
      logic [AGE_W-1:0] r_age [NUM_SETS][NUM_WAYS];
      logic [AGE_W-1:0] w_thr, w_old_age;

      // Filling an invalid way treats it as oldest so ages stay a permutation.
      always_comb begin
        w_thr = r_age[w_touch_idx][w_touch_way];
        if (r_state == S_FILL && !r_valid[w_fill_idx][r_victim])
          w_thr = AGE_W'(NUM_WAYS - 1);
        w_old_way = '0;
        w_old_age = r_age[w_fill_idx][0];
        for (int w = 1; w < NUM_WAYS; w++) begin
          if (r_age[w_fill_idx][w] > w_old_age) begin
            w_old_age = r_age[w_fill_idx][w];
            w_old_way = WAY_W'(w);
          end
        end
      end

      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          for (int s = 0; s < NUM_SETS; s++)
            for (int w = 0; w < NUM_WAYS; w++) r_age[s][w] <= '0;
        end else if (w_touch) begin
          for (int w = 0; w < NUM_WAYS; w++) begin
            if (WAY_W'(w) == w_touch_way) r_age[w_touch_idx][w] <= '0;
            else if (r_age[w_touch_idx][w] < w_thr)
              r_age[w_touch_idx][w] <= r_age[w_touch_idx][w] + AGE_W'(1);
          end
        end
      end
    end else begin : g_no_lru
      assign w_old_way = '0;
    end
  endgenerate

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 1'b0;
    fill_ready  = 1'b0;
    evict_valid = 1'b0;
    evict_addr  = '0;
    evict_data  = '0;
    case (r_state)
      S_IDLE: begin
        req_ready = r_ready_en && !fill_valid;
        if (fill_valid) w_state_nxt = w_victim_dirty ? S_EVICT : S_FILL;
      end
      S_EVICT: begin
        evict_valid = 1'b1;
        evict_addr  = 32'({r_tag[w_fill_idx][r_victim], w_fill_idx, 3'b000});
        evict_data  = r_data[w_fill_idx][r_victim];
        if (evict_ready) w_state_nxt = S_FILL;
      end
      S_FILL: begin
        fill_ready  = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (w_store_hit) r_data[w_req_idx][w_hit_way] <= w_merged;
    if (r_state == S_FILL) begin
      r_data[w_fill_idx][r_victim] <= fill_data;
      r_tag[w_fill_idx][r_victim]  <= w_fill_tag;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        r_valid[s] <= '0;
        r_dirty[s] <= '0;
      end
      r_victim        <= '0;
      r_ready_en      <= 1'b0;
      r_resp_valid    <= 1'b0;
      r_resp_hit      <= 1'b0;
      r_resp_is_store <= 1'b0;
      r_resp_data     <= '0;
      r_resp_addr     <= '0;
    end else begin
      r_ready_en   <= 1'b1;
      r_resp_valid <= w_req_fire;
      if (w_req_fire) begin
        r_resp_hit      <= w_hit;
        r_resp_is_store <= req_is_store;
        r_resp_data     <= w_hit ? (req_is_store ? w_merged : w_hit_line) : 64'd0;
        r_resp_addr     <= {req_addr[31:3], 3'b000};
      end
      if (w_store_hit) r_dirty[w_req_idx][w_hit_way] <= 1'b1;
      if (r_state == S_IDLE && fill_valid) r_victim <= w_victim;
      if (r_state == S_FILL) begin
        r_valid[w_fill_idx][r_victim] <= 1'b1;
        r_dirty[w_fill_idx][r_victim] <= 1'b0;
      end
    end
  end

  assign resp_valid    = r_resp_valid;
  assign resp_hit      = r_resp_hit;
  assign resp_is_store = r_resp_is_store;
  assign resp_data     = r_resp_data;
  assign resp_addr     = r_resp_addr;

`ifdef DCACHE_STATS_EN
  logic [31:0] r_hit_cnt, r_miss_cnt, r_evict_cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_hit_cnt   <= '0;
      r_miss_cnt  <= '0;
      r_evict_cnt <= '0;
    end else begin
      if (w_req_fire && w_hit && r_hit_cnt != 32'hFFFF_FFFF) r_hit_cnt <= r_hit_cnt + 32'd1;
      if (w_req_fire && !w_hit && r_miss_cnt != 32'hFFFF_FFFF) r_miss_cnt <= r_miss_cnt + 32'd1;
      if (evict_valid && evict_ready && r_evict_cnt != 32'hFFFF_FFFF)
        r_evict_cnt <= r_evict_cnt + 32'd1;
    end
  end

  assign hit_count   = r_hit_cnt;
  assign miss_count  = r_miss_cnt;
  assign evict_count = r_evict_cnt;
`endif
endmodule

// File: tb/tb_dcache_assoc.sv
// tb/tb_dcache_assoc.sv - directed self-checking bench for dcache_assoc (NUM_SETS=16, NUM_WAYS=2)
module tb_dcache_assoc;
  logic        clock = 1'b0;
  logic        reset_n;
  logic        req_valid, req_ready, req_is_store;
  logic [31:0] req_addr, req_data;
  logic [1:0]  req_size;
  logic        resp_valid, resp_hit, resp_is_store;
  logic [63:0] resp_data;
  logic [31:0] resp_addr;
  logic        fill_valid, fill_ready;
  logic [31:0] fill_addr;
  logic [63:0] fill_data;
  logic        evict_valid, evict_ready;
  logic [31:0] evict_addr;
  logic [63:0] evict_data;
`ifdef DCACHE_STATS_EN
  logic [31:0] hit_count, miss_count, evict_count;
`endif

  int checks = 0;
  int failures = 0;
  int sb_hit = 0;
  int sb_miss = 0;
  int sb_evict = 0;

  localparam logic [1:0] BYTE = 2'd0;
  localparam logic [1:0] HALF = 2'd1;
  localparam logic [1:0] WORD = 2'd2;

  localparam logic [63:0] D1 = 64'h1122_3344_5566_7788;
  localparam logic [63:0] D2 = 64'hA5A5_0000_5A5A_1111;
  localparam logic [63:0] D3 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] DV = 64'h99EF_3344_CAFE_F00D;

  always #5 clock = ~clock;

  dcache_assoc #(.NUM_SETS(16), .NUM_WAYS(2), .ADDR_W(16)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_is_store(req_is_store), .req_size(req_size), .req_data(req_data),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_is_store(resp_is_store),
    .resp_data(resp_data), .resp_addr(resp_addr),
    .fill_valid(fill_valid), .fill_addr(fill_addr), .fill_data(fill_data), .fill_ready(fill_ready),
    .evict_valid(evict_valid), .evict_addr(evict_addr), .evict_data(evict_data),
    .evict_ready(evict_ready)
`ifdef DCACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count), .evict_count(evict_count)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic do_req(input string tag, input logic [31:0] addr, input logic st,
                        input logic [1:0] sz, input logic [31:0] d,
                        input logic exp_hit, input logic [63:0] exp_data);
    req_valid = 1'b1; req_addr = addr; req_is_store = st; req_size = sz; req_data = d;
    #1 chk({tag, "_req_ready"}, 64'(req_ready), 64'd1);
    tick;
    req_valid = 1'b0;
    chk({tag, "_resp_valid"}, 64'(resp_valid), 64'd1);
    chk({tag, "_resp_hit"}, 64'(resp_hit), 64'(exp_hit));
    chk({tag, "_resp_data"}, resp_data, exp_data);
    chk({tag, "_resp_addr"}, 64'(resp_addr), 64'({addr[31:3], 3'b000}));
    chk({tag, "_resp_is_store"}, 64'(resp_is_store), 64'(st));
    if (exp_hit) sb_hit++;
    else sb_miss++;
  endtask

  task automatic do_fill_clean(input string tag, input logic [31:0] addr, input logic [63:0] d);
    fill_valid = 1'b1; fill_addr = addr; fill_data = d;
    #1 chk({tag, "_req_ready_low"}, 64'(req_ready), 64'd0);
    tick;
    chk({tag, "_fill_ready"}, 64'(fill_ready), 64'd1);
    chk({tag, "_no_evict"}, 64'(evict_valid), 64'd0);
    tick;
    fill_valid = 1'b0;
    chk({tag, "_fill_ready_drop"}, 64'(fill_ready), 64'd0);
  endtask

  initial begin
    reset_n = 1'b0;
    req_valid = 1'b0; req_addr = '0; req_is_store = 1'b0; req_size = BYTE; req_data = '0;
    fill_valid = 1'b0; fill_addr = '0; fill_data = '0; evict_ready = 1'b0;
    tick;
    tick;
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_data", resp_data, 64'd0);
    chk("rst_fill_ready", 64'(fill_ready), 64'd0);
    chk("rst_evict_valid", 64'(evict_valid), 64'd0);
    chk("rst_evict_addr", 64'(evict_addr), 64'd0);
    reset_n = 1'b1;
    #1 chk("rel_req_ready_before_edge", 64'(req_ready), 64'd0);
    tick;
    chk("rel_req_ready_after_edge", 64'(req_ready), 64'd1);

    do_req("ld40_cold", 32'h0000_0040, 1'b0, BYTE, 32'h0, 1'b0, 64'd0);
    chk("ld40_resp_one_cycle", 64'(resp_valid), 64'd1);
    tick;
    chk("ld40_resp_drop", 64'(resp_valid), 64'd0);

    do_fill_clean("fill40", 32'h0000_0040, D1);
    do_req("ld44", 32'h0000_0044, 1'b0, BYTE, 32'h0, 1'b1, D1);
    do_req("stb42", 32'h0000_0042, 1'b1, BYTE, 32'h0000_00AB, 1'b1, 64'h1122_3344_55AB_7788);
    do_req("ld40_after_st", 32'h0000_0040, 1'b0, BYTE, 32'h0, 1'b1, 64'h1122_3344_55AB_7788);
    do_req("sth46", 32'h0000_0046, 1'b1, HALF, 32'h1234_BEEF, 1'b1, 64'hBEEF_3344_55AB_7788);
    do_req("stw41", 32'h0000_0041, 1'b1, WORD, 32'hCAFE_F00D, 1'b1, 64'hBEEF_3344_CAFE_F00D);

    // fill and request in the same cycle
    fill_valid = 1'b1; fill_addr = 32'h0000_0440; fill_data = D2;
    req_valid = 1'b1; req_addr = 32'h0000_0440; req_is_store = 1'b0; req_size = BYTE;
    #1 chk("coll_req_ready_low", 64'(req_ready), 64'd0);
    tick;
    chk("coll_fill_ready", 64'(fill_ready), 64'd1);
    chk("coll_req_ready_fill", 64'(req_ready), 64'd0);
    chk("coll_no_resp", 64'(resp_valid), 64'd0);
    tick;
    fill_valid = 1'b0;
    do_req("coll_ld440", 32'h0000_0440, 1'b0, BYTE, 32'h0, 1'b1, D2);

    do_req("stb47", 32'h0000_0047, 1'b1, BYTE, 32'h0000_0099, 1'b1, DV);
    do_req("ld440_touch", 32'h0000_0440, 1'b0, BYTE, 32'h0, 1'b1, D2);

    // dirty victim 0x040 evicted by fill of 0x840, with eviction back-pressure
    fill_valid = 1'b1; fill_addr = 32'h0000_0840; fill_data = D3; evict_ready = 1'b0;
    #1 chk("ev_req_ready_low", 64'(req_ready), 64'd0);
    for (int c = 0; c < 3; c++) begin
      tick;
      chk($sformatf("ev_valid_c%0d", c), 64'(evict_valid), 64'd1);
      chk($sformatf("ev_addr_c%0d", c), 64'(evict_addr), 64'h40);
      chk($sformatf("ev_data_c%0d", c), evict_data, DV);
      chk($sformatf("ev_no_fill_c%0d", c), 64'(fill_ready), 64'd0);
    end
    evict_ready = 1'b1;
    sb_evict++;
    tick;
    evict_ready = 1'b0;
    chk("ev_fill_ready", 64'(fill_ready), 64'd1);
    chk("ev_valid_drop", 64'(evict_valid), 64'd0);
    tick;
    fill_valid = 1'b0;
    chk("ev_fill_ready_drop", 64'(fill_ready), 64'd0);

    do_req("post_ev_ld440", 32'h0000_0440, 1'b0, BYTE, 32'h0, 1'b1, D2);
    do_req("post_ev_ld840", 32'h0000_0840, 1'b0, BYTE, 32'h0, 1'b1, D3);
    do_req("ld10440_hi_ignored", 32'h0001_0440, 1'b0, BYTE, 32'h0, 1'b1, D2);
    do_req("post_ev_ld040", 32'h0000_0040, 1'b0, BYTE, 32'h0, 1'b0, 64'd0);

`ifdef DCACHE_STATS_EN
    chk("stats_hit", 64'(hit_count), 64'(sb_hit));
    chk("stats_miss", 64'(miss_count), 64'(sb_miss));
    chk("stats_evict", 64'(evict_count), 64'(sb_evict));
`endif

    // reset asserted while a dirty eviction of 0x840 is pending
    do_req("stw840", 32'h0000_0840, 1'b1, WORD, 32'h1111_1111, 1'b1, 64'h0123_4567_1111_1111);
    do_req("ld440_again", 32'h0000_0440, 1'b0, BYTE, 32'h0, 1'b1, D2);
    fill_valid = 1'b1; fill_addr = 32'h0000_0C40; fill_data = 64'hDEAD_BEEF_0000_0001;
    tick;
    chk("rst_ev_valid", 64'(evict_valid), 64'd1);
    chk("rst_ev_addr", 64'(evict_addr), 64'h840);
    chk("rst_ev_data", evict_data, 64'h0123_4567_1111_1111);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_evict_valid", 64'(evict_valid), 64'd0);
    chk("midrst_evict_addr", 64'(evict_addr), 64'd0);
    chk("midrst_evict_data", evict_data, 64'd0);
    chk("midrst_fill_ready", 64'(fill_ready), 64'd0);
    chk("midrst_req_ready", 64'(req_ready), 64'd0);
    chk("midrst_resp_valid", 64'(resp_valid), 64'd0);
    chk("midrst_resp_data", resp_data, 64'd0);
    fill_valid = 1'b0;
    tick;
    reset_n = 1'b1;
    tick;
    do_req("midrst_ld440_miss", 32'h0000_0440, 1'b0, BYTE, 32'h0, 1'b0, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dcache_assoc.md
Name: dcache_assoc

Overview:
Parametrised set-associative, write-back data cache. It is the successor to the direct-mapped, write-allocate-only dcache. It sits between the load/store unit and the MSHR/memory interface.
- Adds configurable ways, LRU replacement, per-line dirty bits, and a dirty-victim eviction handshake.
- Lookups are registered: the response is returned one cycle after the request.

Parameters:
- NUM_SETS, 16: number of sets; power of two, 2 or more.
- NUM_WAYS, 2: associativity; power of two, 1 to 8.
- ADDR_W, 16: number of cached address bits.
  - Offset is addr[2:0].
  - Index is addr[2+log2(NUM_SETS):3].
  - Tag is the remaining bits up to addr[ADDR_W-1]. Bits above ADDR_W-1 are ignored.

Ports:
- clock, in, 1: sole clock; all state updates on posedge.
- reset_n, in, 1: asynchronous, active-low reset.
- req_valid, in, 1: lookup request.
- req_ready, out, 1: high only in IDLE with fill_valid low.
- req_addr, in, 32: byte address.
- req_is_store, in, 1: 1 = store, 0 = load.
- req_size, in, MEM_SIZE: BYTE, HALF or WORD (stores only).
- req_data, in, 32: store data, low-aligned.
- resp_valid, out, 1: one cycle after an accepted request.
- resp_hit, out, 1: hit flag for the response.
- resp_is_store, out, 1: echoes req_is_store.
- resp_data, out, MEM_BLOCK: full line, post-merge for store hits; 0 on a miss.
- resp_addr, out, 32: {req_addr[31:3], 3'b0}.
- fill_valid, in, 1: MSHR delivers a line.
- fill_addr, in, 32: line address of the fill.
- fill_data, in, MEM_BLOCK: fill line.
- fill_ready, out, 1: fill accepted (the cycle the line is written).
- evict_valid, out, 1: dirty victim writeback pending.
- evict_addr, out, 32: victim line address, {tag, index, 3'b0}.
- evict_data, out, MEM_BLOCK: victim line.
- evict_ready, in, 1: memory accepts the eviction.

Behaviour:
- Reset (reset_n low, asynchronous):
  - All valid, dirty and LRU state is cleared; FSM goes to IDLE.
  - All outputs are 0; req_ready rises on the first clock edge after reset_n deasserts.
  - Data array contents are don't-care.
- FSM states are IDLE, EVICT and FILL. Requests are accepted only in IDLE.
- IDLE, request (req_valid && req_ready):
  - Tags of all ways in the set are compared in the same cycle.
  - Next cycle, resp_valid=1 and resp_hit reflects the compare result.
  - Load hit: resp_data is the stored line; the way's LRU age is updated.
  - Store hit: the byte, half or word at the offset is merged into the line, written that edge, and the line is marked dirty; resp_data is the merged line; LRU is updated.
  - Half and word placement follow addr[2:1] and addr[2]; misaligned low bits are ignored.
  - Any miss: no array or LRU change. The requester allocates an MSHR and replays the request after the fill.
- IDLE, fill_valid: fill has priority over requests; req_ready is 0 in that cycle. Victim way selection:
  - the lowest-index invalid way, else
  - the way with maximum LRU age.
  - If the victim is valid and dirty, go to EVICT. Otherwise go to FILL.
- EVICT:
  - evict_valid=1, with evict_addr and evict_data held stable until evict_ready.
  - On evict_valid && evict_ready, go to FILL.
- FILL:
  - Write fill_data into the victim way; set valid=1, dirty=0 and tag; that way becomes MRU.
  - fill_ready=1 for exactly this cycle; then return to IDLE.
  - The fill source holds fill_valid, fill_addr and fill_data stable until fill_ready.
- Total fill latency: 1 cycle if the victim is clean, 2+ cycles if dirty.
- LRU: true LRU with log2(NUM_WAYS)-bit ages per way.
  - On touch, ways younger than the touched way increment and the touched way goes to 0.
  - When NUM_WAYS=1, LRU logic is absent and the victim is always way 0.
- Fill for a line already resident (duplicate): overwrite the matching way in place, with dirty=0 and no eviction.
- reset_n asserted during EVICT or FILL: the state is aborted immediately; no partial write is required to survive.

Optional Feature:
- DCACHE_STATS_EN
- Defined:
  - Adds outputs hit_count[31:0], miss_count[31:0] and evict_count[31:0].
  - Each counter increments on a hit response, a miss response, and an accepted eviction (evict_valid && evict_ready), respectively.
  - Counters saturate at 32'hFFFF_FFFF and clear on reset_n.
- Undefined: the ports and counters are absent and there is no behavioural change.

Test Plan:
- Reset, then load 0x0000_0040: resp_valid on cycle +1 with resp_hit=0 and resp_data=0; req_ready=1 throughout.
- Fill 0x40 with 0x1122334455667788, then load 0x44: fill_ready pulses 1 cycle later; resp_hit=1 and resp_data=0x1122334455667788.
- Store BYTE 0xAB to 0x42 after the above: resp_data=0x1122334455AB7788; a subsequent load of 0x40 returns the same value.
- NUM_SETS=16, NUM_WAYS=2: fill 0x040, then 0x440 (same set); dirty 0x040 with a store; touch 0x440; then fill 0x840.
  - Expected: evict_valid with evict_addr=0x040 and the dirty data; evict_ready held low 3 cycles keeps the outputs stable.
  - 0x840 is then written; 0x440 still hits and 0x040 misses.
- fill_valid and req_valid asserted in the same cycle: req_ready=0 that cycle; the request is accepted the cycle after fill_ready.
- With DCACHE_STATS_EN: after the sequence above, hit_count, miss_count and evict_count match the scoreboard totals.
- Assert reset_n low mid-EVICT: all outputs are 0 immediately; the next load of 0x440 misses.
